vdp_host_bridge: RTL and testbench

VDP_HOST_BRIDGE -- requirements
Module: vdp_host_bridge

---
 rtl/vdp_host_bridge.sv | 131 +++++++++++++
 tb/tb_vdp_host_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_host_bridge.sv
// CPU-to-VDP host bridge: posts CPU writes through a small FIFO and serialises
// them, together with blocking CPU reads, onto the VDP strobe/ready handshake.
module vdp_host_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [5:0]  cpu_address,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [15:0] cpu_rdata,
  output logic [5:0]  host_address,
  output logic        host_write_en,
  output logic [15:0] host_write_data,
  output logic        host_read_en,
  input  logic [15:0] host_read_data,
  input  logic        vdp_ready,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_GAP,
    READ,
    READ_DONE
  } state_t;

  typedef struct packed {
    logic [5:0]  address;
    logic [15:0] data;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  state_t           state;
  state_t           state_next;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic read_accept;
  logic read_done;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);

  // The !cpu_ready term stops a request still held high in its own
  // completion cycle from being taken a second time.
  assign push        = cpu_valid && cpu_we && !fifo_full && !cpu_ready;
  assign read_accept = cpu_valid && !cpu_we && !cpu_ready && fifo_empty && (state == IDLE);
  assign pop         = (state == WRITE) && vdp_ready;
  assign read_done   = (state == READ) && vdp_ready;
  assign busy        = !fifo_empty || (state != IDLE);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_next    = state;
    host_write_en = 1'b0;
    host_read_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty)      state_next = WRITE;
        else if (read_accept) state_next = READ;
      end
      WRITE: begin
        host_write_en = 1'b1;
        if (vdp_ready) state_next = WRITE_GAP;
      end
      WRITE_GAP: state_next = IDLE;
      READ: begin
        host_read_en = 1'b1;
        if (vdp_ready) state_next = READ_DONE;
      end
      READ_DONE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: storage is not reset; count and pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_address, cpu_wdata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      cpu_ready       <= 1'b0;
      cpu_rdata       <= '0;
      host_address    <= '0;
      host_write_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase

      cpu_ready <= push || read_done;
      if (read_done) cpu_rdata <= host_read_data;

      // The head stays in the FIFO until the VDP accepts it, so address and
      // data remain stable for the whole WRITE phase.
      if ((state == IDLE) && !fifo_empty) begin
        host_address    <= mem[rd_ptr].address;
        host_write_data <= mem[rd_ptr].data;
      end else if (read_accept) begin
        host_address <= cpu_address;
      end
    end
  end

endmodule

// File: tb/tb_vdp_host_bridge.sv
// Directed bench for vdp_host_bridge: posted writes are scoreboarded and
// matched against what the VDP side accepts; reads and resets checked inline.
module tb_vdp_host_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid;
  logic        cpu_we;
  logic [5:0]  cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic [5:0]  host_address;
  logic        host_write_en;
  logic [15:0] host_write_data;
  logic        host_read_en;
  logic [15:0] host_read_data;
  logic        vdp_ready;
  logic        busy;

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t exp_w;

  int n_checks = 0;
  int n_passed = 0;
  int n_failed = 0;

  logic vdp_manual     = 1'b0;
  logic vdp_auto_pulse = 1'b0;
  bit   vdp_auto       = 1'b0;
  int   vdp_delay      = 1;
  int   wait_cnt       = 0;
  bit   mon_en         = 1'b0;

  logic        prev_we        = 1'b0;
  logic        prev_re        = 1'b0;
  logic        prev_done      = 1'b0;
  logic        prev_cpu_ready = 1'b0;
  logic [5:0]  prev_addr      = '0;
  logic [15:0] prev_data      = '0;
  int          we_run         = 0;
  int          last_we_run    = 0;
  logic [5:0]  exp_read_addr  = '0;

  assign vdp_ready = vdp_manual | vdp_auto_pulse;

  vdp_host_bridge #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_valid       (cpu_valid),
    .cpu_we          (cpu_we),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_ready       (cpu_ready),
    .cpu_rdata       (cpu_rdata),
    .host_address    (host_address),
    .host_write_en   (host_write_en),
    .host_write_data (host_write_data),
    .host_read_en    (host_read_en),
    .host_read_data  (host_read_data),
    .vdp_ready       (vdp_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // VDP model: answers a held strobe with a one-cycle ready after vdp_delay cycles.
  always @(posedge clk) begin
    #1;
    if (!vdp_auto) begin
      wait_cnt       = 0;
      vdp_auto_pulse = 1'b0;
    end else if ((host_write_en || host_read_en) && !vdp_auto_pulse) begin
      if (wait_cnt >= vdp_delay - 1) begin
        vdp_auto_pulse = 1'b1;
        wait_cnt       = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      vdp_auto_pulse = 1'b0;
    end
  end

  // Protocol monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_mutex", host_write_en && host_read_en, 1'b0);
      if (prev_cpu_ready) check("ready_single_pulse", cpu_ready, 1'b0);
      if (prev_done)      check("write_gap", host_write_en, 1'b0);
      if (host_write_en && prev_we)
        check("write_stable", {host_address, host_write_data}, {prev_addr, prev_data});
      if (host_write_en && vdp_ready) begin
        check("write_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check("write_entry", {host_address, host_write_data}, exp_w);
        end
      end
      if (host_read_en && !prev_re) begin
        check("read_after_writes", sb.size(), 0);
        check("read_after_gap", prev_we, 1'b0);
        check("read_addr", host_address, exp_read_addr);
      end
      if (host_write_en) we_run++;
      else if (we_run != 0) begin
        last_we_run = we_run;
        we_run      = 0;
      end
    end
    prev_we        = host_write_en;
    prev_re        = host_read_en;
    prev_done      = host_write_en && vdp_ready;
    prev_cpu_ready = cpu_ready;
    prev_addr      = host_address;
    prev_data      = host_write_data;
  end

  // Stimulus tasks assume they start just after a rising edge.
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic start_write(input logic [5:0] a, input logic [15:0] d);
    cpu_valid   = 1'b1;
    cpu_we      = 1'b1;
    cpu_address = a;
    cpu_wdata   = d;
    sb.push_back({a, d});
  endtask

  task automatic start_read(input logic [5:0] a);
    cpu_valid     = 1'b1;
    cpu_we        = 1'b0;
    cpu_address   = a;
    exp_read_addr = a;
  endtask

  task automatic wait_ready(input string tag, input int max, output int n);
    n = 0;
    for (int i = 1; i <= max && n == 0; i++) begin
      @(negedge clk);
      if (cpu_ready) n = i;
    end
    check({tag, "_ready_seen"}, n != 0, 1'b1);
  endtask

  task automatic end_req();
    align();
    cpu_valid = 1'b0;
  endtask

  // A posted write into a non-full FIFO completes on the cycle after accept.
  task automatic post_write(input string tag, input logic [5:0] a, input logic [15:0] d);
    int n;
    start_write(a, d);
    wait_ready(tag, 20, n);
    check({tag, "_latency"}, n, 2);
    end_req();
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    check({tag, "_drained"}, done, 1'b1);
  endtask

  task automatic expect_stall(input string tag, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (cpu_ready) seen = 1'b1;
    end
    check({tag, "_stall"}, seen, 1'b0);
  endtask

  initial begin
    int  n;
    bit  seen;
    reset_n        = 1'b0;
    cpu_valid      = 1'b0;
    cpu_we         = 1'b0;
    cpu_address    = '0;
    cpu_wdata      = '0;
    host_read_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_write_en", host_write_en, 1'b0);
    check("rst_read_en", host_read_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_address", host_address, 6'h00);
    check("rst_write_data", host_write_data, 16'h0000);
    check("rst_cpu_rdata", cpu_rdata, 16'h0000);
    align();
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single posted write, VDP answers in the third strobe cycle.
    vdp_auto  = 1'b1;
    vdp_delay = 3;
    post_write("single", 6'h05, 16'hBEEF);
    wait_idle("single", 40);
    check("single_we_cycles", last_we_run, 3);

    // A ready pulse with nothing in flight must be ignored.
    vdp_auto = 1'b0;
    align();
    vdp_manual = 1'b1;
    align();
    vdp_manual = 1'b0;
    @(negedge clk);
    check("idle_ready_busy", busy, 1'b0);
    check("idle_ready_we", host_write_en, 1'b0);

    // Fill the FIFO with the VDP stalled; the fifth write must wait for a pop.
    align();
    for (int i = 0; i < 4; i++) post_write("fill", 6'(6'h20 + i), 16'(16'hA000 + i));
    start_write(6'h24, 16'hA004);
    expect_stall("overflow", 6);
    check("overflow_head_addr", host_address, 6'h20);
    check("overflow_head_data", host_write_data, 16'hA000);
    check("overflow_busy", busy, 1'b1);
    align();
    vdp_manual = 1'b1;
    align();
    vdp_manual = 1'b0;
    wait_ready("overflow_release", 10, n);
    end_req();
    vdp_auto  = 1'b1;
    vdp_delay = 1;
    wait_idle("overflow", 100);

    // Push in the same cycle the head is popped, then prove occupancy is exactly 4.
    vdp_auto = 1'b0;
    align();
    post_write("sim_a", 6'h30, 16'h3000);
    post_write("sim_b", 6'h31, 16'h3111);
    start_write(6'h32, 16'h3222);
    vdp_manual = 1'b1;
    align();
    vdp_manual = 1'b0;
    wait_ready("sim_c", 10, n);
    check("sim_push_pop_latency", n, 1);
    end_req();
    post_write("sim_d", 6'h33, 16'h3333);
    post_write("sim_e", 6'h34, 16'h3444);
    start_write(6'h35, 16'h3555);
    expect_stall("sim_capacity", 6);
    vdp_auto  = 1'b1;
    vdp_delay = 2;
    wait_ready("sim_f", 60, n);
    end_req();
    wait_idle("sim", 200);

    // Read queued behind two posted writes.
    align();
    host_read_data = 16'h1234;
    post_write("rw1", 6'h01, 16'h1111);
    post_write("rw2", 6'h02, 16'h2222);
    start_read(6'h10);
    wait_ready("read1", 100, n);
    check("read1_data", cpu_rdata, 16'h1234);
    check("read1_strobe_low", host_read_en, 1'b0);
    end_req();

    // cpu_rdata holds across writes until the next read completes.
    host_read_data = 16'hFFFF;
    post_write("hold_w", 6'h03, 16'h3333);
    wait_idle("hold", 40);
    check("rdata_hold", cpu_rdata, 16'h1234);
    align();
    host_read_data = 16'hA5C3;
    vdp_delay      = 1;
    start_read(6'h3F);
    wait_ready("read2", 40, n);
    check("read2_data", cpu_rdata, 16'hA5C3);
    end_req();

    // Reset with one write in flight and more queued: everything is dropped.
    vdp_auto = 1'b0;
    align();
    post_write("rst_q0", 6'h3A, 16'h0A0A);
    post_write("rst_q1", 6'h3B, 16'h0B0B);
    post_write("rst_q2", 6'h3C, 16'h0C0C);
    check("midw_in_write", host_write_en, 1'b1);
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midw_write_en", host_write_en, 1'b0);
    check("midw_read_en", host_read_en, 1'b0);
    check("midw_busy", busy, 1'b0);
    check("midw_cpu_ready", cpu_ready, 1'b0);
    align();
    reset_n  = 1'b1;
    vdp_auto = 1'b1;
    seen     = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (host_write_en) seen = 1'b1;
    end
    check("midw_no_stale_write", seen, 1'b0);
    check("midw_busy_after", busy, 1'b0);

    // Reset during a read: no completion may reach the CPU.
    vdp_auto = 1'b0;
    align();
    start_read(6'h11);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (host_read_en) seen = 1'b1;
    end
    check("midr_read_started", seen, 1'b1);
    align();
    reset_n   = 1'b0;
    cpu_valid = 1'b0;
    align();
    reset_n = 1'b1;
    expect_stall("midr_no_ready", 8);
    check("midr_read_en", host_read_en, 1'b0);
    check("midr_rdata_kept_reset", cpu_rdata, 16'h0000);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
